// File: rtl/qam_symbol_mapper_if.sv
// Symbol output bus between the QAM mapper and the downstream shaping/NCO stage.
// The mapper drives the master side; the consumer drives sym_ready.
interface qam_symbol_mapper_if #(
  parameter int BITS_PER_SYM = 4,
  parameter int AMP_W        = 8
);
  logic signed [AMP_W-1:0]  sym_i;
  logic signed [AMP_W-1:0]  sym_q;
  logic [BITS_PER_SYM-1:0]  sym_bits;
  logic                     sym_valid;
  logic                     sym_ready;

  modport master (output sym_i, output sym_q, output sym_bits, output sym_valid, input  sym_ready);
  modport slave  (input  sym_i, input  sym_q, input  sym_bits, input  sym_valid, output sym_ready);
endinterface

// File: rtl/qam_symbol_mapper.sv
// Pulls PN bits one at a time from m_seq_gen, packs them into square-QAM symbols,
// Gray-maps them to signed I/Q levels and presents them on a valid/ready bus.
module qam_symbol_mapper #(
  parameter int BITS_PER_SYM = 4,
  parameter int AMP_W        = 8,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic                bit_req,
  input  logic                bit_in,
  qam_symbol_mapper_if.master sym_bus,
  output logic [CNT_W-1:0]    sym_cnt,
  output logic                busy
);

  localparam int H    = BITS_PER_SYM / 2;
  localparam int L    = 1 << H;
  localparam int BC_W = $clog2(BITS_PER_SYM + 1);

  typedef enum logic [1:0] {IDLE, REQ, CAP, HOLD} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [BITS_PER_SYM-1:0] shreg;
  logic [BC_W-1:0]         bit_cnt;
  logic                    slot_free;
  logic                    hold_xfer;
  logic                    accept;

  // Gray-decode one axis and centre it: index k maps to 2k-(L-1).
  function automatic logic signed [AMP_W-1:0] gray_level(input logic [H-1:0] g);
    logic [H-1:0] k;
    int           lvl;
    k[H-1] = g[H-1];
    for (int n = H - 2; n >= 0; n--) begin
      k[n] = k[n+1] ^ g[n];
    end
    lvl = 2 * int'(k) - (L - 1);
    return AMP_W'(lvl);
  endfunction

  assign slot_free = !sym_bus.sym_valid || sym_bus.sym_ready;
  assign hold_xfer = (state == HOLD) && slot_free;
  assign accept    = sym_bus.sym_valid && sym_bus.sym_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = REQ;
      REQ:  state_nxt = CAP;
      CAP:  state_nxt = (bit_cnt == BC_W'(BITS_PER_SYM - 1)) ? HOLD : REQ;
      HOLD: if (slot_free) state_nxt = enable ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // REQ never follows REQ, so the registered pulse is always isolated.
  always_ff @(posedge clk) begin
    if (rst) bit_req <= 1'b0;
    else     bit_req <= (state_nxt == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (state == CAP) begin
      shreg   <= {shreg[BITS_PER_SYM-2:0], bit_in};
      bit_cnt <= bit_cnt + BC_W'(1);
    end else if (hold_xfer) begin
      bit_cnt <= '0;
    end
  end

  // A HOLD transfer in the same cycle as an accept keeps sym_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_bus.sym_valid <= 1'b0;
      sym_bus.sym_bits  <= '0;
      sym_bus.sym_i     <= '0;
      sym_bus.sym_q     <= '0;
    end else if (hold_xfer) begin
      sym_bus.sym_valid <= 1'b1;
      sym_bus.sym_bits  <= shreg;
      sym_bus.sym_i     <= gray_level(shreg[BITS_PER_SYM-1:H]);
      sym_bus.sym_q     <= gray_level(shreg[H-1:0]);
    end else if (accept) begin
      sym_bus.sym_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         sym_cnt <= '0;
    else if (accept) sym_cnt <= sym_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Scoreboard bench for qam_symbol_mapper: a 16-QAM instance and a QPSK instance
// with a narrow counter, both fed by bench-generated bit sources.
module tb_qam_symbol_mapper;

  typedef struct {
    int bits;
    int i;
    int q;
  } sym_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b;
  logic       bit_req_a, bit_req_b;
  logic       bit_in_a, bit_in_b;
  logic       busy_a, busy_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int   tests = 0;
  int   fails = 0;

  sym_t sb_a[$];
  sym_t sb_b[$];
  int   pat_a[$];
  int   pat_b[$];
  int   nbits_a, acc_bits_a, req_a, pushed_a, acc_a;
  int   nbits_b, acc_bits_b, acc_b;
  logic prev_req_a, prev_req_b;

  always #5 clk = ~clk;

  qam_symbol_mapper_if #(.BITS_PER_SYM(4), .AMP_W(8)) bus_a ();
  qam_symbol_mapper_if #(.BITS_PER_SYM(2), .AMP_W(4)) bus_b ();

  qam_symbol_mapper #(.BITS_PER_SYM(4), .AMP_W(8), .CNT_W(16)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .enable  (en_a),
    .bit_req (bit_req_a),
    .bit_in  (bit_in_a),
    .sym_bus (bus_a),
    .sym_cnt (cnt_a),
    .busy    (busy_a)
  );

  qam_symbol_mapper #(.BITS_PER_SYM(2), .AMP_W(4), .CNT_W(4)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .enable  (en_b),
    .bit_req (bit_req_b),
    .bit_in  (bit_in_b),
    .sym_bus (bus_b),
    .sym_cnt (cnt_b),
    .busy    (busy_b)
  );

  task automatic checkOutput(input string tag, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ea, input logic eb, input logic rdy);
    @(posedge clk);
    #1;
    en_a            = ea;
    en_b            = eb;
    bus_a.sym_ready = rdy;
  endtask

  // 16-QAM axis table: Gray pairs 00,01,11,10 -> -3,-1,+1,+3.
  function automatic int lvl16(input int two);
    case (two)
      0:       return -3;
      1:       return -1;
      3:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int lvl4(input int b);
    return (b != 0) ? 1 : -1;
  endfunction

  // Bit source and scoreboard for the 16-QAM instance.
  always @(negedge clk) begin : mon_a
    int   b;
    sym_t e;
    if (rst) begin
      sb_a.delete();
      nbits_a = 0; acc_bits_a = 0; req_a = 0; pushed_a = 0; acc_a = 0;
      prev_req_a = 1'b0;
    end else begin
      if (bit_req_a) begin
        checkOutput("a_req_gap", int'(prev_req_a), 0);
        b = (pat_a.size() > 0) ? pat_a.pop_front() : int'($urandom_range(0, 1));
        bit_in_a   = b[0];
        req_a++;
        acc_bits_a = (acc_bits_a << 1) | (b & 1);
        nbits_a++;
        if (nbits_a == 4) begin
          sb_a.push_back('{acc_bits_a, lvl16(acc_bits_a >> 2), lvl16(acc_bits_a & 3)});
          pushed_a++;
          nbits_a    = 0;
          acc_bits_a = 0;
        end
      end
      prev_req_a = bit_req_a;
      if (bus_a.sym_valid && bus_a.sym_ready) begin
        if (sb_a.size() == 0) begin
          checkOutput("a_sb_empty", 1, 0);
        end else begin
          e = sb_a.pop_front();
          checkOutput("a_bits", int'(bus_a.sym_bits), e.bits);
          checkOutput("a_i", int'(bus_a.sym_i), e.i);
          checkOutput("a_q", int'(bus_a.sym_q), e.q);
        end
        checkOutput("a_cnt", int'(cnt_a), acc_a % 65536);
        acc_a++;
      end
    end
  end

  // Bit source and scoreboard for the QPSK instance.
  always @(negedge clk) begin : mon_b
    int   b;
    sym_t e;
    if (rst) begin
      sb_b.delete();
      nbits_b = 0; acc_bits_b = 0; acc_b = 0;
      prev_req_b = 1'b0;
    end else begin
      if (bit_req_b) begin
        checkOutput("b_req_gap", int'(prev_req_b), 0);
        b = (pat_b.size() > 0) ? pat_b.pop_front() : int'($urandom_range(0, 1));
        bit_in_b   = b[0];
        acc_bits_b = (acc_bits_b << 1) | (b & 1);
        nbits_b++;
        if (nbits_b == 2) begin
          sb_b.push_back('{acc_bits_b, lvl4(acc_bits_b >> 1), lvl4(acc_bits_b & 1)});
          nbits_b    = 0;
          acc_bits_b = 0;
        end
      end
      prev_req_b = bit_req_b;
      if (bus_b.sym_valid && bus_b.sym_ready) begin
        if (sb_b.size() == 0) begin
          checkOutput("b_sb_empty", 1, 0);
        end else begin
          e = sb_b.pop_front();
          checkOutput("b_bits", int'(bus_b.sym_bits), e.bits);
          checkOutput("b_i", int'(bus_b.sym_i), e.i);
          checkOutput("b_q", int'(bus_b.sym_q), e.q);
        end
        checkOutput("b_cnt", int'(cnt_b), acc_b % 16);
        acc_b++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mask;
    int first_v;
    int k;
    int r20;

    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    bit_in_a = 1'b0; bit_in_b = 1'b0;
    bus_a.sym_ready = 1'b1;
    bus_b.sym_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", int'(bus_a.sym_valid), 0);
    checkOutput("rst_i", int'(bus_a.sym_i), 0);
    checkOutput("rst_q", int'(bus_a.sym_q), 0);
    checkOutput("rst_bits", int'(bus_a.sym_bits), 0);
    checkOutput("rst_cnt", int'(cnt_a), 0);
    checkOutput("rst_busy", int'(busy_a), 0);
    checkOutput("rst_req", int'(bit_req_a), 0);
    checkOutput("rst_b_valid", int'(bus_b.sym_valid), 0);

    @(posedge clk); #1 rst = 1'b0;
    pat_a = '{1, 1, 1, 0, 1, 0, 1, 1};

    // Latency: enable rises in IDLE during cycle 0.
    applyStimulus(1'b1, 1'b0, 1'b1);
    mask = 0; first_v = -1;
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bit_req_a && c <= 8) mask |= (1 << c);
      if (bus_a.sym_valid && first_v < 0) begin
        first_v = c;
        checkOutput("first_bits", int'(bus_a.sym_bits), 14);
        checkOutput("first_i", int'(bus_a.sym_i), 1);
        checkOutput("first_q", int'(bus_a.sym_q), 3);
      end
    end
    checkOutput("req_cycles", mask, 32'hAA);
    checkOutput("first_valid_cycle", first_v, 10);

    k = 0;
    while (cnt_a != 16'd2 && k < 40) begin @(negedge clk); k++; end
    checkOutput("cnt_after_two", int'(cnt_a), 2);

    // Backpressure: hold the output, let the mapper park in HOLD.
    applyStimulus(1'b1, 1'b0, 1'b0);
    k = 0;
    while (!bus_a.sym_valid && k < 30) begin @(negedge clk); k++; end
    checkOutput("bp_valid_seen", int'(bus_a.sym_valid), 1);
    r20 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 20) r20 = req_a;
      checkOutput("bp_valid", int'(bus_a.sym_valid), 1);
      if (sb_a.size() > 0) checkOutput("bp_bits", int'(bus_a.sym_bits), sb_a[0].bits);
      else                 checkOutput("bp_sb_depth", 0, 1);
    end
    checkOutput("bp_no_req", req_a - r20, 0);
    checkOutput("bp_pending", sb_a.size(), 2);
    checkOutput("bp_busy", int'(busy_a), 1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("b2b_valid", int'(bus_a.sym_valid), 1);
    if (sb_a.size() > 0) checkOutput("b2b_bits", int'(bus_a.sym_bits), sb_a[0].bits);
    else                 checkOutput("b2b_sb_depth", 0, 1);

    // Random backpressure soak.
    for (int c = 0; c < 1000; c++) begin
      applyStimulus(1'b1, 1'b0, logic'($urandom_range(0, 1)));
    end
    applyStimulus(1'b1, 1'b0, 1'b1);

    // Drop enable after the second request of a symbol.
    k = 0;
    do begin @(posedge clk); k++; end while (nbits_a != 2 && k < 40);
    checkOutput("wait_two_bits", nbits_a, 2);
    #1 en_a = 1'b0;
    k = 0;
    while (busy_a && k < 40) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    checkOutput("drop_busy", int'(busy_a), 0);
    checkOutput("drop_req", int'(bit_req_a), 0);
    checkOutput("drop_partial", nbits_a, 0);
    checkOutput("drop_sb_empty", sb_a.size(), 0);
    checkOutput("drop_valid", int'(bus_a.sym_valid), 0);
    checkOutput("req_per_sym", req_a, 4 * pushed_a);

    // Reset in the middle of a symbol.
    applyStimulus(1'b1, 1'b0, 1'b1);
    k = 0;
    do begin @(posedge clk); k++; end while (nbits_a != 3 && k < 40);
    checkOutput("wait_three_bits", nbits_a, 3);
    #1 rst = 1'b1;
    pat_a = '{0, 1, 1, 0};
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_valid", int'(bus_a.sym_valid), 0);
    checkOutput("mid_rst_bits", int'(bus_a.sym_bits), 0);
    checkOutput("mid_rst_i", int'(bus_a.sym_i), 0);
    checkOutput("mid_rst_q", int'(bus_a.sym_q), 0);
    checkOutput("mid_rst_cnt", int'(cnt_a), 0);
    checkOutput("mid_rst_busy", int'(busy_a), 0);
    checkOutput("mid_rst_req", int'(bit_req_a), 0);
    k = 0;
    while (!bus_a.sym_valid && k < 30) begin @(negedge clk); k++; end
    checkOutput("fresh_bits", int'(bus_a.sym_bits), 6);
    checkOutput("fresh_i", int'(bus_a.sym_i), -1);
    checkOutput("fresh_q", int'(bus_a.sym_q), 3);

    // QPSK instance: all four points, then counter wrap.
    applyStimulus(1'b0, 1'b0, 1'b1);
    pat_b = '{0, 0, 0, 1, 1, 1, 1, 0};
    applyStimulus(1'b0, 1'b1, 1'b1);
    k = 0;
    while (acc_b < 17 && k < 300) begin @(negedge clk); k++; end
    checkOutput("b_accepts", int'(acc_b >= 17), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("b_idle", int'(busy_b), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
